// File: rtl/pio_seg7_scan.sv
// rtl/pio_seg7_scan.sv - 4-digit multiplexed seven-segment scanner fed by an 8-bit PIO
// Define SEG7_CHG_CNT_EN to enable the PIO change counter shown on digits 3:2.
module pio_seg7_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] pio_in,
    output logic [6:0] seg_n,
    output logic [3:0] dig_n,
    output logic [7:0] chg_cnt
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
    localparam logic [DIV_W-1:0] SLOT_LAST  = DIV_W'(SCAN_DIV - 1);
`ifdef SEG7_CHG_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_pio_q;
    logic [6:0]       r_seg;
    logic [7:0]       w_cnt;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic [3:0]       w_dig_n;
    logic             w_chg;

    assign w_chg = (pio_in != r_pio_q);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_pio_q <= 8'h00;
        end else if (w_chg) begin
            r_pio_q <= pio_in;
        end
    end

`ifdef SEG7_CHG_CNT_EN
    logic [7:0] r_chg_cnt;
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_chg_cnt <= 8'h00;
        end else if (w_chg) begin
            r_chg_cnt <= r_chg_cnt + 8'd1;
        end
    end
    assign w_cnt = r_chg_cnt;
`else
    assign w_cnt = 8'h00;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= ST_BLANK;
            r_div   <= '0;
            r_idx   <= 2'd0;
            r_seg   <= 7'h7F;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_idx   <= w_idx_nxt;
            r_seg   <= w_seg;
        end
    end

    // div runs freely through the slot; only the ON state ends a slot
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div + 1'b1;
        w_idx_nxt   = r_idx;
        w_dig_n     = 4'hF;
        case (r_state)
            ST_BLANK: begin
                if (r_div == BLANK_LAST) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (CNT_EN || !r_idx[1]) begin
                    w_dig_n = ~(4'b0001 << r_idx);
                end
                if (r_div == SLOT_LAST) begin
                    w_div_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = ST_BLANK;
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            2'd0: w_nib = r_pio_q[3:0];
            2'd1: w_nib = r_pio_q[7:4];
            2'd2: w_nib = w_cnt[3:0];
            2'd3: w_nib = w_cnt[7:4];
            default: w_nib = 4'h0;
        endcase
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    assign seg_n   = r_seg;
    assign dig_n   = w_dig_n;
    assign chg_cnt = w_cnt;
endmodule

// File: tb/tb_pio_seg7_scan.sv
// tb/tb_pio_seg7_scan.sv - randomized check of pio_seg7_scan against a slot/frame arithmetic model
// Honours SEG7_CHG_CNT_EN the same way as the design.
module tb_pio_seg7_scan;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
`ifdef SEG7_CHG_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic [7:0] pio_in;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
    logic [7:0] chg_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pio_seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .pio_in     (pio_in),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .chg_cnt    (chg_cnt)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference: position in the frame follows from cycles elapsed since reset release
    initial begin
        int         m_n;
        int         div;
        int         idx;
        logic [7:0] m_q;
        logic [7:0] m_c;
        logic [7:0] shown;
        logic [6:0] m_seg;
        logic [3:0] e_dig;
        logic [3:0] one;
        m_n = 0; m_q = 8'h00; m_c = 8'h00; m_seg = 7'h7F; one = 4'b0001;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                m_n = 0; m_q = 8'h00; m_c = 8'h00; m_seg = 7'h7F;
                chk("rst_dig_n", {4'h0, dig_n}, 8'h0F);
                chk("rst_seg_n", {1'b0, seg_n}, 8'h7F);
                chk("rst_chg_cnt", chg_cnt, 8'h00);
            end else begin
                div = m_n % SCAN_DIV;
                idx = (m_n / SCAN_DIV) % 4;
                e_dig = (div >= BLANK_CYC && (CNT_EN || idx < 2)) ? ~(one << idx) : 4'hF;
                chk("m_dig_n", {4'h0, dig_n}, {4'h0, e_dig});
                chk("m_seg_n", {1'b0, seg_n}, {1'b0, m_seg});
                chk("m_chg_cnt", chg_cnt, CNT_EN ? m_c : 8'h00);
                shown = (idx < 2) ? m_q : (CNT_EN ? m_c : 8'h00);
                m_seg = dec7(idx[0] ? shown[7:4] : shown[3:0]);
                if (pio_in !== m_q) begin
                    m_q = pio_in;
                    m_c = m_c + 8'd1;
                end
                m_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #2;
    endtask

    task automatic reset_to_cycle0();
        reset_reset = 1'b1;
        pio_in = 8'h00;
        step(2);
        reset_reset = 1'b0;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) pio_in = 8'($urandom);
            step(1);
        end
    endtask

    initial begin
        reset_reset = 1'b1;
        pio_in = 8'h00;
        #3;
        chk("async_rst_dig", {4'h0, dig_n}, 8'h0F);
        reset_to_cycle0();
        chk("c0_dig", {4'h0, dig_n}, 8'h0F);
        chk("c0_seg", {1'b0, seg_n}, 8'h7F);
        step(1);
        chk("c1_dig", {4'h0, dig_n}, 8'h0F);
        chk("c1_seg", {1'b0, seg_n}, 8'h40);
        step(1);
        chk("c2_dig", {4'h0, dig_n}, 8'h0E);
        step(5);
        chk("c7_dig", {4'h0, dig_n}, 8'h0E);
        step(1);
        chk("c8_dig", {4'h0, dig_n}, 8'h0F);
        step(2);
        chk("c10_dig", {4'h0, dig_n}, 8'h0D);

        pio_in = 8'hA5;
        step(1);
        chk("a5_cnt", chg_cnt, CNT_EN ? 8'h01 : 8'h00);
        step(23);
        chk("a5_s0_seg", {1'b0, seg_n}, 8'h12);
        chk("a5_s0_dig", {4'h0, dig_n}, 8'h0E);
        step(8);
        chk("a5_s1_seg", {1'b0, seg_n}, 8'h08);
        chk("a5_s1_dig", {4'h0, dig_n}, 8'h0D);
        step(8);
        chk("a5_s2_seg", {1'b0, seg_n}, CNT_EN ? 8'h79 : 8'h40);
        chk("a5_s2_dig", {4'h0, dig_n}, CNT_EN ? 8'h0B : 8'h0F);
        step(8);
        chk("a5_s3_seg", {1'b0, seg_n}, 8'h40);
        chk("a5_s3_dig", {4'h0, dig_n}, CNT_EN ? 8'h07 : 8'h0F);

        random_run(400);

        reset_to_cycle0();
        for (int i = 1; i <= 256; i++) begin
            pio_in = ~pio_in;
            step(1);
            if (i == 255) chk("tog255_cnt", chg_cnt, CNT_EN ? 8'hFF : 8'h00);
        end
        chk("tog256_cnt", chg_cnt, 8'h00);
        step(100);
        chk("hold_cnt", chg_cnt, 8'h00);

        reset_to_cycle0();
        step(31);
        pio_in = 8'h3C;
        step(1);
        chk("wrap_dig", {4'h0, dig_n}, 8'h0F);
        chk("wrap_cnt", chg_cnt, CNT_EN ? 8'h01 : 8'h00);
        step(1);
        chk("wrap_seg", {1'b0, seg_n}, 8'h46);
        step(1);
        chk("wrap_on_dig", {4'h0, dig_n}, 8'h0E);

        step(18);
        reset_reset = 1'b1;
        #1;
        chk("mid_rst_dig", {4'h0, dig_n}, 8'h0F);
        chk("mid_rst_seg", {1'b0, seg_n}, 8'h7F);
        chk("mid_rst_cnt", chg_cnt, 8'h00);
        step(1);
        reset_reset = 1'b0;
        pio_in = 8'h00;
        step(2);
        chk("restart_dig", {4'h0, dig_n}, 8'h0E);

        for (int i = 0; i < 5; i++) begin
            pio_in = pio_in + 8'h11;
            step(3);
        end
        chk("five_cnt", chg_cnt, CNT_EN ? 8'h05 : 8'h00);
        random_run(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
